// File: rtl/uart_tx_byte_fifo.sv
// Byte FIFO feeding a UART transmit controller over its SEND/DATA/READY handshake.
// A byte is popped only when the controller is idle, and each pop gives exactly one SEND pulse.
//   state     | meaning
//   IDLE      | wait for a stored byte and READY high, then pop it
//   SEND      | SEND pulse is high and DATA is stable
//   WAIT_BUSY | wait for the controller to drop READY
//   WAIT_RDY  | wait for the controller to raise READY again
module uart_tx_byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    input  logic              flush_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    input  logic              tx_ready_i,
    output logic              tx_send_o,
    output logic [7:0]        tx_data_o
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_RDY} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                tx_send_q, tx_send_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [7:0]          mem_q [DEPTH];
    logic                push;
    logic                pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign tx_send_o  = tx_send_q;
    assign tx_data_o  = tx_data_q;

    // FULL comes from the registered count, so a write while full is dropped even if a pop happens that cycle.
    assign push = wr_en_i && !full_o && !flush_i;

    always_comb begin
        state_d   = state_q;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_o && tx_ready_i && !flush_i) begin
                    pop       = 1'b1;
                    tx_send_d = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = SEND;
                end
            end
            SEND:      state_d = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready_i) state_d = WAIT_RDY;
            WAIT_RDY:  if (tx_ready_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (push && !pop)      count_d = count_q + (ADDR_W+1)'(1);
            else if (!push && pop) count_d = count_q - (ADDR_W+1)'(1);
            if (wr_en_i && full_o) overflow_d = 1'b1;
        end
    end

    // Flush leaves the FSM and TX_DATA alone so a send already under way still completes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_send_q  <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_send_q  <= tx_send_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule
